// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned NPORT = 2;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] wdata;
    logic            err;
    logic            port;
  } req_t;

  // Any set bit above the word index addresses past the end of memory.
  function automatic logic addr_err(input logic [XLEN-1:0] addr);
    return |addr[XLEN-1:AW];
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way grant picker: fixed priority to port 0, or round-robin on the
// last-grant pointer when DMEM_ARB_RR_EN is defined.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [NPORT-1:0] valid,
`ifdef DMEM_ARB_RR_EN
  input  logic             last,
`endif
  output logic [NPORT-1:0] grant
);

  always_comb begin
    grant = '0;
`ifdef DMEM_ARB_RR_EN
    // last = 1 means port 1 was served most recently, so port 0 wins a tie.
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
`else
    grant[0] = valid[0];
    grant[1] = valid[1] & ~valid[0];
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared 64-bit data memory.
// Optional round-robin arbitration via DMEM_ARB_RR_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPORT-1:0] req_valid,
  output logic [NPORT-1:0] req_ready,
  input  logic [NPORT-1:0] req_we,
  input  logic [XLEN-1:0]  req_addr0,
  input  logic [XLEN-1:0]  req_addr1,
  input  logic [XLEN-1:0]  req_wdata0,
  input  logic [XLEN-1:0]  req_wdata1,
  output logic [NPORT-1:0] rsp_valid,
  output logic             rsp_err,
  output logic [XLEN-1:0]  rsp_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic [XLEN-1:0]  mem_rdata
);

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  logic [NPORT-1:0] rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [XLEN-1:0]  rsp_rdata_q, rsp_rdata_d;

  logic [NPORT-1:0] grant;
  logic             open;
  logic             accept;
  logic             access_ok;
  logic [XLEN-1:0]  sel_addr;
  req_t             new_req;

`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = grant[1];
    end
  end

  dmem_arb_pick u_pick (
    .valid (req_valid),
    .last  (last_q),
    .grant (grant)
  );
`else
  dmem_arb_pick u_pick (
    .valid (req_valid),
    .grant (grant)
  );
`endif

  // Acceptance window: IDLE or RESP, never while reset is asserted.
  always_comb begin
    open      = rst_n && ((state_q == ST_IDLE) || (state_q == ST_RESP));
    req_ready = open ? grant : '0;
    accept    = |req_ready;

    sel_addr      = grant[1] ? req_addr1 : req_addr0;
    new_req.we    = grant[1] ? req_we[1] : req_we[0];
    new_req.idx   = sel_addr[AW-1:0];
    new_req.wdata = grant[1] ? req_wdata1 : req_wdata0;
    new_req.err   = addr_err(sel_addr);
    new_req.port  = grant[1];
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    if (accept) begin
      req_d = new_req;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Read data is captured straight into the response register.
        state_d     = ST_RESP;
        rsp_valid_d = NPORT'(1) << req_q.port;
        rsp_err_d   = req_q.err;
        if (!req_q.we && !req_q.err) begin
          rsp_rdata_d = mem_rdata;
        end
      end
      ST_RESP: begin
        state_d = accept ? ST_ACCESS : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Memory side decodes only flops; an async reset drops the strobes at once.
  always_comb begin
    access_ok = (state_q == ST_ACCESS) && !req_q.err;
    mem_read  = access_ok && !req_q.we;
    mem_write = access_ok && req_q.we;
    mem_addr  = access_ok ? {(XLEN-AW)'(0), req_q.idx} : '0;
    mem_wdata = (access_ok && req_q.we) ? req_q.wdata : '0;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [63:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [63:0] rsp_rdata;
  logic        mem_read, mem_write;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        preload;

  int total = 0;
  int bad   = 0;

  logic [63:0] mem [256];

  dmem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (mem_write) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; preload = 1'b1;
    req_valid = 2'b01; req_we = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    step(); step();
    chk("rst_ready", 64'(req_ready), 64'(2'b00));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(2'b00));
    chk("rst_rsp_err", 64'(rsp_err), 64'(1'b0));
    chk("rst_rsp_rdata", rsp_rdata, 64'h0);
    chk("rst_mem_read", 64'(mem_read), 64'(1'b0));
    chk("rst_mem_write", 64'(mem_write), 64'(1'b0));
    chk("rst_mem_addr", mem_addr, 64'h0);
    req_valid = 2'b00;
    rst_n = 1'b1; preload = 1'b0;
    step();

    // Port 0 write DEADBEEF to 5
    req_valid = 2'b01; req_we = 2'b01; req_addr0 = 64'd5; req_wdata0 = 64'hDEADBEEF;
    #1 chk("wr_ready", 64'(req_ready), 64'(2'b01));
    step();
    req_valid = 2'b00;
    chk("wr_mem_write", 64'(mem_write), 64'(1'b1));
    chk("wr_mem_read", 64'(mem_read), 64'(1'b0));
    chk("wr_mem_addr", mem_addr, 64'd5);
    chk("wr_mem_wdata", mem_wdata, 64'hDEADBEEF);
    chk("wr_access_rsp", 64'(rsp_valid), 64'(2'b00));
    chk("wr_access_ready", 64'(req_ready), 64'(2'b00));
    step();
    chk("wr_mem_write_1cyc", 64'(mem_write), 64'(1'b0));
    chk("wr_rsp_valid", 64'(rsp_valid), 64'(2'b01));
    chk("wr_rsp_err", 64'(rsp_err), 64'(1'b0));
    chk("wr_rsp_rdata", rsp_rdata, 64'h0);
    step();
    chk("wr_rsp_1cyc", 64'(rsp_valid), 64'(2'b00));

    // Port 0 read back 5
    req_valid = 2'b01; req_we = 2'b00; req_addr0 = 64'd5;
    step();
    req_valid = 2'b00;
    chk("rd5_mem_read", 64'(mem_read), 64'(1'b1));
    step();
    chk("rd5_rsp_valid", 64'(rsp_valid), 64'(2'b01));
    chk("rd5_rdata", rsp_rdata, 64'hDEADBEEF);
    step();

    // Contention: port 0 reads 17, port 1 reads 3
    req_valid = 2'b11; req_we = 2'b00; req_addr0 = 64'd17; req_addr1 = 64'd3;
    #1 chk("arb_ready_first", 64'(req_ready), 64'(2'b01));
    step();
    req_valid = 2'b10;
    chk("arb_access_ready", 64'(req_ready), 64'(2'b00));
    chk("arb_p0_addr", mem_addr, 64'd17);
    step();
    chk("arb_p0_rsp", 64'(rsp_valid), 64'(2'b01));
    chk("arb_p0_rdata", rsp_rdata, 64'hC0DE_0000_0000_0011);
    chk("arb_p1_ready_in_resp", 64'(req_ready), 64'(2'b10));
    step();
    req_valid = 2'b00;
    chk("arb_gap_rsp", 64'(rsp_valid), 64'(2'b00));
    chk("arb_p1_mem_read", 64'(mem_read), 64'(1'b1));
    chk("arb_p1_addr", mem_addr, 64'd3);
    step();
    chk("arb_p1_rsp", 64'(rsp_valid), 64'(2'b10));
    chk("arb_p1_rdata", rsp_rdata, 64'hC0DE_0000_0000_0003);
    step();

    // Port 1 out-of-range read 0x100
    req_valid = 2'b10; req_we = 2'b00; req_addr1 = 64'h100;
    step();
    req_valid = 2'b00;
    chk("oor_mem_read", 64'(mem_read), 64'(1'b0));
    chk("oor_mem_write", 64'(mem_write), 64'(1'b0));
    chk("oor_mem_addr", mem_addr, 64'h0);
    step();
    chk("oor_rsp_valid", 64'(rsp_valid), 64'(2'b10));
    chk("oor_rsp_err", 64'(rsp_err), 64'(1'b1));
    chk("oor_rsp_rdata", rsp_rdata, 64'h0);
    step();

    // Out-of-range write aliasing index 2 must not touch memory
    req_valid = 2'b10; req_we = 2'b10; req_addr1 = 64'h8000_0000_0000_0002; req_wdata1 = 64'h1234;
    step();
    req_valid = 2'b00;
    chk("oorw_mem_write", 64'(mem_write), 64'(1'b0));
    step();
    chk("oorw_rsp_err", 64'(rsp_err), 64'(1'b1));
    step();
    req_valid = 2'b01; req_we = 2'b00; req_addr0 = 64'd2;
    step();
    req_valid = 2'b00;
    step();
    chk("oorw_readback", rsp_rdata, 64'hC0DE_0000_0000_0002);
    step();

    // Reset during ACCESS of a port 0 read
    req_valid = 2'b01; req_we = 2'b00; req_addr0 = 64'd9;
    step();
    req_valid = 2'b00;
    chk("mid_mem_read_pre", 64'(mem_read), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("mid_mem_read_drop", 64'(mem_read), 64'(1'b0));
    chk("mid_mem_addr_drop", mem_addr, 64'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_no_rsp_a", 64'(rsp_valid), 64'(2'b00));
    step();
    chk("mid_no_rsp_b", 64'(rsp_valid), 64'(2'b00));
    req_valid = 2'b01; req_addr0 = 64'd9;
    step();
    req_valid = 2'b00;
    step();
    chk("mid_after_rsp", 64'(rsp_valid), 64'(2'b01));
    chk("mid_after_rdata", rsp_rdata, 64'hC0DE_0000_0000_0009);
    step();

    // Streaming: 10 reads from 20..29 with req_valid held
    req_valid = 2'b01; req_we = 2'b00;
    for (int k = 0; k < 10; k++) begin
      req_addr0 = 64'(20 + k);
      #1 chk("str_ready", 64'(req_ready), 64'(2'b01));
      if (k > 0) begin
        chk("str_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        chk("str_rdata", rsp_rdata, pat(19 + k));
      end
      step();
      if (k == 9) req_valid = 2'b00;
      chk("str_access_ready", 64'(req_ready), 64'(2'b00));
      chk("str_access_rsp", 64'(rsp_valid), 64'(2'b00));
      chk("str_mem_addr", mem_addr, 64'(20 + k));
      step();
    end
    chk("str_last_rsp", 64'(rsp_valid), 64'(2'b01));
    chk("str_last_rdata", rsp_rdata, 64'hC0DE_0000_0000_001D);
    step();
    chk("str_idle_rsp", 64'(rsp_valid), 64'(2'b00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the shared 64-bit data memory (256 words, level-sensitive MemRead/MemWrite, combinational read). Port 0 serves the pipeline MEM stage and port 1 serves the debug/loader port. The block grants one request at a time, drives the memory strobes from registered address and data for exactly one cycle, and returns a registered response with range checking. It sits between the MEM-stage and loader interfaces and the data memory instance.

## Interface
Parameters:
- NPORT, 2: number of requesters. Fixed at 2 in this release.
- DEPTH, 256: memory depth in 64-bit words.
- AW, 8: word-index width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  2  per-port request valid.
- req_ready  out  2  per-port request accepted this cycle when valid & ready.
- req_we  in  2  per-port write flag: 1 = write, 0 = read.
- req_addr0, req_addr1  in  64  per-port word address.
- req_wdata0, req_wdata1  in  64  per-port write data.
- rsp_valid  out  2  per-port one-cycle response strobe.
- rsp_err  out  1  response refers to an out-of-range address; qualified by rsp_valid.
- rsp_rdata  out  64  read data, shared by both ports; qualified by rsp_valid.
- mem_read  out  1  drives the memory MemRead.
- mem_write  out  1  drives the memory MemWrite.
- mem_addr  out  64  drives the memory address: {56'b0, word index}.
- mem_wdata  out  64  drives the memory write_data.
- mem_rdata  in  64  memory read_data.

## Operation
- The FSM has three states:
  - IDLE: waiting for a request.
  - ACCESS: memory strobe cycle.
  - RESP: response cycle.
- req_ready is high only for the granted port, and only in IDLE or RESP. It is combinational from req_valid and the state.
- Arbitration uses fixed priority: port 0 beats port 1. A port whose req_valid is low never receives ready.
- On acceptance the block latches the port id, we, addr[AW-1:0], wdata, and an error flag. The error flag is set when addr[63:AW] != 0. The next state is ACCESS.
- ACCESS lasts exactly one cycle.
  - In range: mem_read = !we and mem_write = we. mem_addr and mem_wdata come only from registers, so the strobes are glitch-free.
  - Read: mem_rdata is captured at the end of ACCESS.
  - Error: both strobes stay 0. The memory is never touched.
- RESP: rsp_valid[port] = 1 for one cycle.
  - rsp_rdata = captured data on an in-range read, otherwise 0.
  - rsp_err = the error flag.
  - A write response acts as an acknowledge.
- From RESP, the next state is ACCESS if a new request is accepted in the same cycle, otherwise IDLE.
- Responses have no backpressure. Requesters must sink rsp_valid.
- Outside an ACCESS cycle, mem_read, mem_write, mem_addr and mem_wdata are 0.
- A requester must hold req_valid, we, addr and wdata stable until it is accepted.

## Timing
- Reset values: state = IDLE; req_ready = 0 (but ready may rise combinationally while rst_n is high and in IDLE); rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; mem_* = 0; round-robin pointer = port 0.
- Latency: accept at edge T, then ACCESS in cycle T+1, then rsp_valid in cycle T+2.
- Throughput: one access per 2 cycles when requests are continuous.
- Simultaneous valid on both ports: one grant per acceptance, following the priority rule. The loser keeps waiting and is not accepted in the same cycle.
- Reset mid-operation: state returns to IDLE asynchronously and no response is ever issued for the abandoned transaction. mem_write drops immediately. A write in its ACCESS cycle has an undefined effect on memory.
- Back-to-back accesses to the same address: a read issued after a write sees the written data, because the write completes in an earlier ACCESS cycle.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-grant pointer makes the most recently granted port lowest priority on the next contention.
  - The pointer updates on every acceptance and resets to "port 1 last", so port 0 wins the first contention.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins, and no pointer flop exists.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the DEPTH and AW constants;
  - a request struct {we, addr index, wdata, err, port}.
- One sub-module, dmem_arb_pick: a combinational two-way grant picker with the round-robin pointer input. It compiles to fixed priority without DMEM_ARB_RR_EN.
- FSM, latches and response registers live in the top module.

## Test plan
- Port 0 writes 64'hDEADBEEF to addr 5, then reads addr 5. Required:
  - mem_write is high for exactly 1 cycle.
  - The write's rsp_valid[0] arrives at T+2 with rsp_err = 0.
  - The read returns rsp_rdata = 64'hDEADBEEF.
- Both ports request on the same cycle: port 0 reads addr 17, port 1 reads addr 3.
  - Fixed build: port 0 is served first, port 1 is accepted in port 0's RESP cycle, and the responses are 2 cycles apart.
  - RR build: after 4 contended pairs, the grants alternate 0,1,0,1.
- Port 1 reads addr 64'h100 (out of range). Required: mem_read and mem_write stay 0, and rsp_valid[1] arrives with rsp_err = 1 and rsp_rdata = 0.
- rst_n is pulsed low during ACCESS of a port 0 read. Required: all outputs go to 0 immediately, no rsp_valid follows, and a subsequent request completes normally.
- Port 0 holds req_valid continuously for 10 reads of incrementing addresses. Required: req_ready is accepted every 2 cycles and rsp_valid[0] pulses every 2 cycles with the correct data.
